// File: rtl/sm4_pkg.sv
// Shared SM4 types, constants and linear transforms used by the round engine.
// Word 0 of any 128-bit quantity is bits [127:96].
package sm4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_KEY    = 1'b1;
  localparam logic MODE_CIPHER = 1'b0;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // Cipher transform L(B) = B ^ rotl2 ^ rotl10 ^ rotl18 ^ rotl24
  function automatic logic [31:0] l_enc(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
             ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  // Key-schedule transform L'(B) = B ^ rotl13 ^ rotl23
  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // CK(i): byte j (j=0 is MSB) = (4i+j)*7 mod 256; 8-bit arithmetic wraps for us.
  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] r;
    logic [7:0]  base;
    r    = '0;
    base = {1'b0, i, 2'b00};
    for (int j = 0; j < 4; j++) begin
      r[31 - 8*j -: 8] = (base + 8'(j)) * 8'd7;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm4_round_engine_if.sv
// Request, round-key and result signals of the SM4 round engine.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// in_valid/out_valid and their payloads stay stable until that edge. rk_valid is a
// one-cycle pulse with no ready.
interface sm4_round_engine_if #(parameter int ROUNDS = 32);
  localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic             dec;
  logic [127:0]     din;
  logic [CNT_W-1:0] rk_addr;
  logic [31:0]      rk_in;
  logic             rk_valid;
  logic [CNT_W-1:0] rk_idx;
  logic [31:0]      rk_out;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     dout;

  modport master (
    output in_valid, mode, dec, din, rk_in, out_ready,
    input  in_ready, rk_addr, rk_valid, rk_idx, rk_out, out_valid, dout
  );

  modport slave (
    input  in_valid, mode, dec, din, rk_in, out_ready,
    output in_ready, rk_addr, rk_valid, rk_idx, rk_out, out_valid, dout
  );
endinterface

// File: rtl/S_BOX.sv
// SM4 S-box byte substitution with one cycle of registered latency.
module S_BOX (
  input  logic       clk,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Entry 0 sits in the top byte, so entry n starts at bit 8*(255-n) = {~n, 3'b000}.
  localparam logic [2047:0] ROM = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic [10:0] idx;
  assign idx = {~din, 3'b000};

  always_ff @(posedge clk) begin
    dout <= ROM[idx +: 8];
  end
endmodule

// File: rtl/sm4_lin_xform.sv
// Selects the cipher transform L or the key-schedule transform L' on the S-box word.
module sm4_lin_xform
  import sm4_pkg::*;
(
  input  logic [31:0] b,
  input  logic        mode,
  output logic [31:0] y
);
  assign y = (mode == MODE_KEY) ? l_key(b) : l_enc(b);
endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 engine: one round takes RUN_A (form T, feed S-boxes) and RUN_B
// (linear transform, shift X); the same datapath does key expansion or cipher rounds.
module sm4_round_engine
  import sm4_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic              CLK,
  input  logic              RST,
  sm4_round_engine_if.slave bus,
  output state_t            dbg_state
);
  localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] round_q;
  logic             mode_q, dec_q;
  logic [31:0]      x0_q, x1_q, x2_q, x3_q;
  logic [31:0]      k_word, t_word, b_word, l_word;
  logic             accept, last_round, rk_fire;

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign last_round = (round_q == LAST);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN_A;
      end
      RUN_A: state_d = RUN_B;
      RUN_B: state_d = last_round ? DONE : RUN_A;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rk_in only matters in RUN_A; the S-box registers capture T at the RUN_A edge.
  assign k_word = (mode_q == MODE_KEY) ? ck(5'(round_q)) : bus.rk_in;
  assign t_word = x1_q ^ x2_q ^ x3_q ^ k_word;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    S_BOX u_sbox (
      .clk  (CLK),
      .din  (t_word[8*g +: 8]),
      .dout (b_word[8*g +: 8])
    );
  end

  sm4_lin_xform u_lin (
    .b    (b_word),
    .mode (mode_q),
    .y    (l_word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      round_q <= '0;
      mode_q  <= MODE_CIPHER;
      dec_q   <= 1'b0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mode_q  <= bus.mode;
          dec_q   <= bus.dec & (bus.mode == MODE_CIPHER);
          round_q <= '0;
          {x0_q, x1_q, x2_q, x3_q} <= (bus.mode == MODE_KEY) ? (bus.din ^ FK) : bus.din;
        end
        RUN_B: begin
          {x0_q, x1_q, x2_q, x3_q} <= {x1_q, x2_q, x3_q, x0_q ^ l_word};
          if (!last_round) round_q <= round_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rk_fire      = (state_q == RUN_B) && (mode_q == MODE_KEY);
  assign bus.rk_valid = rk_fire;
  assign bus.rk_out   = rk_fire ? (x0_q ^ l_word) : '0;
  assign bus.rk_idx   = rk_fire ? round_q : '0;
  assign bus.rk_addr  = dec_q ? (LAST - round_q) : round_q;
  assign bus.dout     = (state_q != DONE)      ? '0 :
                        (mode_q == MODE_KEY)   ? {x0_q, x1_q, x2_q, x3_q} :
                                                 {x3_q, x2_q, x1_q, x0_q};
  assign dbg_state    = state_q;
endmodule
